// File: rtl/dbus_xbar_n.sv
// Data-bus switch from the core data port to N address-windowed slaves.
// Fast slaves answer one cycle after the strobe; slow slaves use a busy handshake with a timeout watchdog.
module dbus_xbar_n #(
    parameter int N_SLAVES = 4,
    parameter logic [32*N_SLAVES-1:0] SLV_BASE = {32'h80000000, 32'h40000000, 32'h00080000, 32'h00000000},
    parameter logic [32*N_SLAVES-1:0] SLV_MASK = {32'h80000000, 32'hFFFF0000, 32'hFFFE0000, 32'hFFFFE000},
    parameter logic [N_SLAVES-1:0]    SLV_SLOW = 4'b1000,
    parameter int TIMEOUT = 1024
) (
    input  logic                    CLK,
    input  logic                    RST_X,
    input  logic [31:0]             C_ADDR,
    input  logic [31:0]             C_WDATA,
    input  logic [3:0]              C_WE,
    input  logic                    C_RE,
    output logic [31:0]             C_RDATA,
    output logic                    C_STALL,
    output logic                    C_ERR,
    output logic [31:0]             ERR_ADDR,
    output logic [31:0]             S_ADDR,
    output logic [31:0]             S_WDATA,
    output logic [4*N_SLAVES-1:0]   S_WE,
    output logic [N_SLAVES-1:0]     S_RE,
    input  logic [32*N_SLAVES-1:0]  S_RDATA,
    input  logic [N_SLAVES-1:0]     S_BUSY
);
    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {SRC_ZERO, SRC_HOLD, SRC_FAST} src_t;

    state_t           state, state_nxt;
    src_t             src_kind;
    logic [SEL_W-1:0] src_idx, r_sel, hit_idx;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      l_addr, l_wdata, r_rdata;
    logic             hit_any, access, slow_hit, busy_sel;
    logic [31:0]      srd [N_SLAVES];

    for (genvar g = 0; g < N_SLAVES; g++) begin : g_rd
        assign srd[g] = S_RDATA[32*g +: 32];
    end

    assign access   = C_RE | (|C_WE);
    assign slow_hit = SLV_SLOW[hit_idx];
    assign busy_sel = S_BUSY[r_sel];

    // Scan downwards so the lowest matching window wins on overlap.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((C_ADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit_any = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (access && hit_any && slow_hit) state_nxt = WAIT;
            WAIT:    if (!busy_sel || cnt == CNT_LAST) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        S_WE    = '0;
        S_RE    = '0;
        C_STALL = 1'b0;
        S_ADDR  = (state == WAIT) ? l_addr  : C_ADDR;
        S_WDATA = (state == WAIT) ? l_wdata : C_WDATA;
        if (RST_X && state == IDLE && access && hit_any) begin
            for (int i = 0; i < N_SLAVES; i++) begin
                if (hit_idx == SEL_W'(i)) begin
                    S_WE[4*i +: 4] = C_WE;
                    S_RE[i]        = C_RE;
                end
            end
            C_STALL = slow_hit;
        end
        if (RST_X && state == WAIT) C_STALL = 1'b1;
    end

    // The read source only moves on an accepted access, so held data survives idle cycles.
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            src_kind <= SRC_ZERO;
            src_idx  <= '0;
            r_sel    <= '0;
            r_rdata  <= '0;
            cnt      <= '0;
            l_addr   <= '0;
            l_wdata  <= '0;
            C_ERR    <= 1'b0;
            ERR_ADDR <= '0;
        end else begin
            C_ERR <= 1'b0;
            case (state)
                IDLE: if (access) begin
                    if (!hit_any) begin
                        src_kind <= SRC_ZERO;
                        C_ERR    <= 1'b1;
                        ERR_ADDR <= C_ADDR;
                    end else if (slow_hit) begin
                        l_addr  <= C_ADDR;
                        l_wdata <= C_WDATA;
                        r_sel   <= hit_idx;
                        cnt     <= '0;
                    end else begin
                        src_kind <= SRC_FAST;
                        src_idx  <= hit_idx;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (!busy_sel) begin
                        r_rdata  <= srd[r_sel];
                        src_kind <= SRC_HOLD;
                    end else if (cnt == CNT_LAST) begin
                        r_rdata  <= '0;
                        src_kind <= SRC_HOLD;
                        C_ERR    <= 1'b1;
                        ERR_ADDR <= l_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (src_kind)
            SRC_FAST: C_RDATA = srd[src_idx];
            SRC_HOLD: C_RDATA = r_rdata;
            default:  C_RDATA = '0;
        endcase
    end
endmodule

// File: tb/tb_dbus_xbar_n.sv
// Self-checking bench for dbus_xbar_n: directed scenarios plus a randomized run
// against a transaction-level model of the address map and slave timing.
module tb_dbus_xbar_n;
    localparam int TO = 8;

    logic         CLK = 1'b0;
    logic         RST_X = 1'b0;
    logic [31:0]  C_ADDR = '0, C_WDATA = '0;
    logic [3:0]   C_WE = '0;
    logic         C_RE = 1'b0;
    logic [31:0]  C_RDATA, ERR_ADDR, S_ADDR, S_WDATA;
    logic         C_STALL, C_ERR;
    logic [15:0]  S_WE;
    logic [3:0]   S_RE;
    logic [127:0] S_RDATA;
    logic [3:0]   S_BUSY = '0;
    logic [31:0]  srd [4];

    int n_cmp = 0;
    int n_bad = 0;

    assign S_RDATA = {srd[3], srd[2], srd[1], srd[0]};

    dbus_xbar_n #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RST_X(RST_X), .C_ADDR(C_ADDR), .C_WDATA(C_WDATA), .C_WE(C_WE), .C_RE(C_RE),
        .C_RDATA(C_RDATA), .C_STALL(C_STALL), .C_ERR(C_ERR), .ERR_ADDR(ERR_ADDR),
        .S_ADDR(S_ADDR), .S_WDATA(S_WDATA), .S_WE(S_WE), .S_RE(S_RE),
        .S_RDATA(S_RDATA), .S_BUSY(S_BUSY)
    );

    always #5 CLK = ~CLK;

    // Address map as stated: lowest index wins, -1 = unmapped.
    function automatic int model_decode(input logic [31:0] a);
        if ((a & 32'hFFFFE000) == 32'h00000000) return 0;
        if ((a & 32'hFFFE0000) == 32'h00080000) return 1;
        if ((a & 32'hFFFF0000) == 32'h40000000) return 2;
        if ((a & 32'h80000000) == 32'h80000000) return 3;
        return -1;
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in;
        C_RE = 1'b0; C_WE = '0; C_ADDR = '0; C_WDATA = '0; S_BUSY = '0;
    endtask

    // Core-side driver for a slow access: holds the request while stalled, slave 3
    // reports busy for the first busy_n cycles. Returns in the first unstalled cycle.
    task automatic drive_slow(input logic [31:0] a, input logic [3:0] we, input logic re,
                              input logic [31:0] wd, input int busy_n, input logic [31:0] rd,
                              output int stalls, output int strobes, output int err_k,
                              output int resp_k, output logic [31:0] rdata0);
        stalls = 0; strobes = 0; err_k = -1; resp_k = -1; rdata0 = '0;
        C_ADDR = a; C_WE = we; C_RE = re; C_WDATA = wd; srd[3] = rd;
        for (int k = 0; k < 60; k++) begin
            S_BUSY = (k < busy_n) ? 4'b1000 : 4'b0000;
            #1;
            if (k == 0) rdata0 = C_RDATA;
            if (C_STALL === 1'b1) stalls++;
            if (S_RE !== 4'b0 || S_WE !== 16'b0) strobes++;
            if (k > 0 && C_ERR === 1'b1) err_k = k;
            if (C_STALL !== 1'b1) begin
                resp_k = k;
                break;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        srd[0] = 32'h0A0A0A0A; srd[1] = 32'h1B1B1B1B; srd[2] = 32'h2C2C2C2C; srd[3] = 32'h3D3D3D3D;
        RST_X = 1'b0; C_RE = 1'b1; C_WE = 4'hF; C_ADDR = 32'h80000000;
        tick; tick;
        n_cmp++; if (S_RE !== 4'b0) begin n_bad++; $display("FAIL rst_s_re got %b exp 0000", S_RE); end
        n_cmp++; if (S_WE !== 16'b0) begin n_bad++; $display("FAIL rst_s_we got %h exp 0000", S_WE); end
        n_cmp++; if (C_STALL !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b exp 0", C_STALL); end
        n_cmp++; if (C_ERR !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b exp 0", C_ERR); end
        n_cmp++; if (ERR_ADDR !== 32'h0) begin n_bad++; $display("FAIL rst_err_addr got %h exp 0", ERR_ADDR); end
        n_cmp++; if (C_RDATA !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h exp 0", C_RDATA); end
        idle_in; RST_X = 1'b1;
        tick;
    endtask

    task automatic test_fast_read;
        srd[0] = 32'h12345678;
        C_RE = 1'b1; C_ADDR = 32'h00000010;
        #1;
        n_cmp++; if (S_RE !== 4'b0001) begin n_bad++; $display("FAIL frd_s_re got %b exp 0001", S_RE); end
        n_cmp++; if (C_STALL !== 1'b0) begin n_bad++; $display("FAIL frd_stall got %b exp 0", C_STALL); end
        n_cmp++; if (S_ADDR !== 32'h00000010) begin n_bad++; $display("FAIL frd_s_addr got %h exp 00000010", S_ADDR); end
        tick; idle_in;
        #1;
        n_cmp++; if (C_RDATA !== 32'h12345678) begin n_bad++; $display("FAIL frd_rdata got %h exp 12345678", C_RDATA); end
        tick;
    endtask

    task automatic test_fast_write;
        C_WE = 4'b0011; C_ADDR = 32'h40000004; C_WDATA = 32'hAABBCCDD;
        #1;
        n_cmp++; if (S_WE !== 16'h0300) begin n_bad++; $display("FAIL fwr_s_we got %h exp 0300", S_WE); end
        n_cmp++; if (S_RE !== 4'b0) begin n_bad++; $display("FAIL fwr_s_re got %b exp 0000", S_RE); end
        n_cmp++; if (S_WDATA !== 32'hAABBCCDD) begin n_bad++; $display("FAIL fwr_s_wdata got %h exp aabbccdd", S_WDATA); end
        n_cmp++; if (C_STALL !== 1'b0) begin n_bad++; $display("FAIL fwr_stall got %b exp 0", C_STALL); end
        tick; idle_in;
        #1;
        n_cmp++; if (S_WE !== 16'h0) begin n_bad++; $display("FAIL fwr_s_we_after got %h exp 0000", S_WE); end
        tick;
    endtask

    task automatic test_slow_read;
        int st, sb, ek, rk;
        logic [31:0] r0;
        drive_slow(32'h80000100, 4'b0, 1'b1, 32'h0, 5, 32'hCAFEF00D, st, sb, ek, rk, r0);
        n_cmp++; if (st != 6) begin n_bad++; $display("FAIL srd_stall_cycles got %0d exp 6", st); end
        n_cmp++; if (sb != 1) begin n_bad++; $display("FAIL srd_strobes got %0d exp 1", sb); end
        n_cmp++; if (rk != 6) begin n_bad++; $display("FAIL srd_resp_cycle got %0d exp 6", rk); end
        n_cmp++; if (ek != -1) begin n_bad++; $display("FAIL srd_err_cycle got %0d exp -1", ek); end
        n_cmp++; if (C_RDATA !== 32'hCAFEF00D) begin n_bad++; $display("FAIL srd_rdata got %h exp cafef00d", C_RDATA); end
        n_cmp++; if (S_RE !== 4'b0) begin n_bad++; $display("FAIL srd_resp_s_re got %b exp 0000", S_RE); end
        tick; idle_in; srd[3] = 32'h0BADBEEF;
        #1;
        n_cmp++; if (C_RDATA !== 32'hCAFEF00D) begin n_bad++; $display("FAIL srd_hold got %h exp cafef00d", C_RDATA); end
        tick;
    endtask

    task automatic test_unmapped;
        C_RE = 1'b1; C_ADDR = 32'h20000000;
        #1;
        n_cmp++; if (S_RE !== 4'b0 || S_WE !== 16'b0) begin n_bad++; $display("FAIL unm_strobes got re=%b we=%h exp 0", S_RE, S_WE); end
        n_cmp++; if (C_STALL !== 1'b0) begin n_bad++; $display("FAIL unm_stall got %b exp 0", C_STALL); end
        tick; idle_in;
        #1;
        n_cmp++; if (C_RDATA !== 32'h0) begin n_bad++; $display("FAIL unm_rdata got %h exp 0", C_RDATA); end
        n_cmp++; if (C_ERR !== 1'b1) begin n_bad++; $display("FAIL unm_err got %b exp 1", C_ERR); end
        n_cmp++; if (ERR_ADDR !== 32'h20000000) begin n_bad++; $display("FAIL unm_err_addr got %h exp 20000000", ERR_ADDR); end
        tick;
        n_cmp++; if (C_ERR !== 1'b0) begin n_bad++; $display("FAIL unm_err_pulse got %b exp 0", C_ERR); end
        n_cmp++; if (ERR_ADDR !== 32'h20000000) begin n_bad++; $display("FAIL unm_err_addr_keep got %h exp 20000000", ERR_ADDR); end
    endtask

    task automatic test_timeout;
        int st, sb, ek, rk;
        logic [31:0] r0;
        drive_slow(32'h80000ABC, 4'hF, 1'b0, 32'h55667788, 1000, 32'hDEADDEAD, st, sb, ek, rk, r0);
        n_cmp++; if (st != TO + 1) begin n_bad++; $display("FAIL to_stall_cycles got %0d exp %0d", st, TO + 1); end
        n_cmp++; if (sb != 1) begin n_bad++; $display("FAIL to_strobes got %0d exp 1", sb); end
        n_cmp++; if (ek != TO + 1) begin n_bad++; $display("FAIL to_err_cycle got %0d exp %0d", ek, TO + 1); end
        n_cmp++; if (ERR_ADDR !== 32'h80000ABC) begin n_bad++; $display("FAIL to_err_addr got %h exp 80000abc", ERR_ADDR); end
        n_cmp++; if (C_RDATA !== 32'h0) begin n_bad++; $display("FAIL to_rdata got %h exp 0", C_RDATA); end
        tick; idle_in;
        #1;
        n_cmp++; if (C_ERR !== 1'b0 || C_STALL !== 1'b0) begin n_bad++; $display("FAIL to_after got err=%b stall=%b exp 0 0", C_ERR, C_STALL); end
        tick;
    endtask

    task automatic test_back_to_back;
        int st, sb, ek, rk;
        logic [31:0] r0;
        srd[0] = 32'h01010101; srd[1] = 32'h02020202; srd[2] = 32'h03030303;
        C_RE = 1'b1; C_ADDR = 32'h00000040;
        #1;
        n_cmp++; if (S_RE !== 4'b0001) begin n_bad++; $display("FAIL b2b_re0 got %b exp 0001", S_RE); end
        tick; C_ADDR = 32'h00080008;
        #1;
        n_cmp++; if (C_RDATA !== 32'h01010101) begin n_bad++; $display("FAIL b2b_rd0 got %h exp 01010101", C_RDATA); end
        n_cmp++; if (S_RE !== 4'b0010 || C_STALL !== 1'b0) begin n_bad++; $display("FAIL b2b_re1 got %b stall=%b exp 0010 0", S_RE, C_STALL); end
        tick; C_RE = 1'b0; C_WE = 4'hF; C_ADDR = 32'h4000FFFC;
        #1;
        n_cmp++; if (C_RDATA !== 32'h02020202) begin n_bad++; $display("FAIL b2b_rd1 got %h exp 02020202", C_RDATA); end
        n_cmp++; if (S_WE !== 16'h0F00) begin n_bad++; $display("FAIL b2b_we2 got %h exp 0f00", S_WE); end
        tick; C_WE = 4'h0; C_RE = 1'b1; C_ADDR = 32'h00000080;
        #1;
        n_cmp++; if (C_RDATA !== 32'h03030303) begin n_bad++; $display("FAIL b2b_rd2 got %h exp 03030303", C_RDATA); end
        tick;
        drive_slow(32'h80000200, 4'b0, 1'b1, 32'h0, 0, 32'h77778888, st, sb, ek, rk, r0);
        n_cmp++; if (r0 !== 32'h01010101) begin n_bad++; $display("FAIL b2b_fast_then_slow got %h exp 01010101", r0); end
        n_cmp++; if (rk != 2) begin n_bad++; $display("FAIL b2b_slow_min_lat got %0d exp 2", rk); end
        n_cmp++; if (C_RDATA !== 32'h77778888) begin n_bad++; $display("FAIL b2b_slow_rdata got %h exp 77778888", C_RDATA); end
        tick; idle_in;
    endtask

    task automatic test_reset_mid_wait;
        srd[1] = 32'h11112222; srd[0] = 32'h33334444;
        C_RE = 1'b1; C_ADDR = 32'h00080010;
        tick;
        C_ADDR = 32'h80000040; S_BUSY = 4'b1000;
        tick; tick;
        #1;
        n_cmp++; if (C_STALL !== 1'b1 || C_RDATA !== 32'h11112222) begin n_bad++; $display("FAIL rmw_in_wait got stall=%b rdata=%h exp 1 11112222", C_STALL, C_RDATA); end
        tick;
        RST_X = 1'b0;
        #1;
        n_cmp++; if (C_STALL !== 1'b0 || S_RE !== 4'b0) begin n_bad++; $display("FAIL rmw_during_rst got stall=%b re=%b exp 0 0000", C_STALL, S_RE); end
        tick; RST_X = 1'b1; idle_in;
        #1;
        n_cmp++; if (C_STALL !== 1'b0 || S_RE !== 4'b0 || S_WE !== 16'b0) begin n_bad++; $display("FAIL rmw_after got stall=%b re=%b we=%h exp 0", C_STALL, S_RE, S_WE); end
        n_cmp++; if (C_ERR !== 1'b0 || C_RDATA !== 32'h0) begin n_bad++; $display("FAIL rmw_after_data got err=%b rdata=%h exp 0 0", C_ERR, C_RDATA); end
        tick;
        n_cmp++; if (C_ERR !== 1'b0) begin n_bad++; $display("FAIL rmw_no_err got %b exp 0", C_ERR); end
        C_RE = 1'b1; C_ADDR = 32'h00000004;
        #1;
        n_cmp++; if (S_RE !== 4'b0001 || C_STALL !== 1'b0) begin n_bad++; $display("FAIL rmw_fast_req got re=%b stall=%b exp 0001 0", S_RE, C_STALL); end
        tick; idle_in;
        #1;
        n_cmp++; if (C_RDATA !== 32'h33334444) begin n_bad++; $display("FAIL rmw_fast_data got %h exp 33334444", C_RDATA); end
        tick;
    endtask

    task automatic test_random;
        int src, idx, bn, st, sb, ek, rk, rk_exp;
        logic [31:0] hold, last_err, a, wd, rd, exp, r0;
        logic [15:0] ew;
        logic [3:0] we, er;
        logic re, exp_err, timed;
        RST_X = 1'b0; idle_in;
        tick;
        RST_X = 1'b1;
        src = -1; hold = '0; last_err = '0; exp_err = 1'b0;
        for (int t = 0; t < 60; t++) begin
            exp = (src >= 0) ? srd[src] : ((src == -2) ? hold : 32'h0);
            n_cmp++; if (C_RDATA !== exp) begin n_bad++; $display("FAIL rnd_rdata[%0d] got %h exp %h", t, C_RDATA, exp); end
            n_cmp++; if (C_ERR !== exp_err) begin n_bad++; $display("FAIL rnd_err[%0d] got %b exp %b", t, C_ERR, exp_err); end
            n_cmp++; if (ERR_ADDR !== last_err) begin n_bad++; $display("FAIL rnd_err_addr[%0d] got %h exp %h", t, ERR_ADDR, last_err); end
            exp_err = 1'b0;
            for (int j = 0; j < 4; j++) srd[j] = $urandom;
            if ($urandom_range(0, 5) == 5) begin
                idle_in;
                tick;
                continue;
            end
            case ($urandom_range(0, 4))
                0: a = {19'h0, 13'($urandom)};
                1: a = 32'h00080000 | {15'h0, 17'($urandom)};
                2: a = 32'h40000000 | {16'h0, 16'($urandom)};
                3: a = {1'b1, 31'($urandom)};
                default: a = 32'h20000000 | {8'h0, 24'($urandom)};
            endcase
            we = 4'($urandom); re = 1'($urandom); wd = $urandom; rd = $urandom;
            if (!re && we == 4'b0) re = 1'b1;
            idx = model_decode(a);
            if (idx == 3) begin
                bn = $urandom_range(0, TO + 3);
                timed = (bn > TO);
                rk_exp = (timed ? TO : ((bn < 1) ? 1 : bn)) + 1;
                drive_slow(a, we, re, wd, bn, rd, st, sb, ek, rk, r0);
                n_cmp++; if (rk != rk_exp || st != rk_exp) begin n_bad++; $display("FAIL rnd_slow_lat[%0d] got resp=%0d stalls=%0d exp %0d", t, rk, st, rk_exp); end
                n_cmp++; if (sb != 1) begin n_bad++; $display("FAIL rnd_slow_strobes[%0d] got %0d exp 1", t, sb); end
                n_cmp++; if (ek != (timed ? rk_exp : -1)) begin n_bad++; $display("FAIL rnd_slow_err[%0d] got %0d exp %0d", t, ek, timed ? rk_exp : -1); end
                hold = timed ? 32'h0 : rd;
                n_cmp++; if (C_RDATA !== hold) begin n_bad++; $display("FAIL rnd_slow_rdata[%0d] got %h exp %h", t, C_RDATA, hold); end
                src = -2;
                if (timed) last_err = a;
                idle_in;
                tick;
            end else begin
                C_ADDR = a; C_WE = we; C_RE = re; C_WDATA = wd;
                #1;
                if (idx >= 0) begin
                    ew = 16'(we) << (4 * idx);
                    er = 4'(re) << idx;
                    src = idx;
                end else begin
                    ew = '0; er = '0;
                    src = -1; exp_err = 1'b1; last_err = a;
                end
                n_cmp++; if (S_WE !== ew || S_RE !== er) begin n_bad++; $display("FAIL rnd_strobes[%0d] got we=%h re=%b exp we=%h re=%b", t, S_WE, S_RE, ew, er); end
                n_cmp++; if (C_STALL !== 1'b0) begin n_bad++; $display("FAIL rnd_stall[%0d] got %b exp 0", t, C_STALL); end
                n_cmp++; if (S_ADDR !== a || S_WDATA !== wd) begin n_bad++; $display("FAIL rnd_bus[%0d] got %h/%h exp %h/%h", t, S_ADDR, S_WDATA, a, wd); end
                tick;
            end
        end
        idle_in;
    endtask

    initial begin
        for (int j = 0; j < 4; j++) srd[j] = '0;
        test_reset;
        test_fast_read;
        test_fast_write;
        test_slow_read;
        test_unmapped;
        test_timeout;
        test_back_to_back;
        test_reset_mid_wait;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
